// File: rtl/lw_rpt_pkg.sv
// Shared constants, the snapshot record and small helpers for the
// cluster-7 lw report collector.
package lw_rpt_pkg;

    // Report geometry: 10 LTL automata, 4 report outputs each.
    localparam int N_LTL       = 10;
    localparam int RPT_PER_LTL = 4;
    localparam int N_RPT       = N_LTL * RPT_PER_LTL;
    localparam int ID_W        = 6;

    // Timestamp, buffering and drop accounting widths.
    localparam int CYC_W       = 32;
    localparam int SNAP_DEPTH  = 4;
    localparam int SNAP_AW     = $clog2(SNAP_DEPTH);
    localparam int DROP_W      = 16;

    // One reporting cycle: the raw report bits and the cycle stamp.
    typedef struct packed {
        logic [N_RPT-1:0] vec;
        logic [CYC_W-1:0] stamp;
    } snap_t;

    // Flat report index of output k (0..3 = out_4/out_6/out_9/out_11)
    // of automaton ltl_n.
    function automatic logic [ID_W-1:0] rpt_index(input int unsigned ltl_n,
                                                  input int unsigned k);
        return ID_W'(ltl_n * RPT_PER_LTL + k);
    endfunction

    // Index of the lowest set bit; returns 0 for an all-zero vector.
    function automatic logic [ID_W-1:0] lowest_set(input logic [N_RPT-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N_RPT - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/lw_rpt_snap_fifo.sv
// Small synchronous FIFO of snapshot records. A push into a full FIFO is
// accepted when the head is popped in the same cycle.
module lw_rpt_snap_fifo
    import lw_rpt_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  i_push,
    input  snap_t i_push_data,
    input  logic  i_pop,
    output snap_t o_head,
    output logic  o_full,
    output logic  o_empty
);

    snap_t              r_mem [SNAP_DEPTH];
    logic [SNAP_AW-1:0] r_wr_ptr;
    logic [SNAP_AW-1:0] r_rd_ptr;
    logic [SNAP_AW:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (SNAP_AW + 1)'(SNAP_DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; depth is a power of two so the
    // pointers simply wrap.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // always_ff samples the pre-edge values of the others.
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the cleared
        // pointers and count already mark every entry as invalid.
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/lw_report_collector_c7.sv
// Report collector for the cluster-7 lw automata stage: stamps each
// reporting symbol cycle, buffers it as a snapshot and serializes its set
// bits as (report id, cycle stamp) events on a valid/ready interface.
module lw_report_collector_c7
    import lw_rpt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [N_RPT-1:0]  report_vec,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [ID_W-1:0]   rpt_id,
    output logic [CYC_W-1:0]  rpt_cycle,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    // Symbol-cycle counter.
    logic [CYC_W-1:0]  r_cycle_cnt;

    // Working copy of the head snapshot once its first bit has been taken.
    logic              r_work_active;
    logic [N_RPT-1:0]  r_work_vec;

    // Output event register.
    logic              r_valid;
    logic [ID_W-1:0]   r_id;
    logic [CYC_W-1:0]  r_cycle;

    // Drop accounting.
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    // FIFO interface.
    snap_t             w_push_data;
    snap_t             w_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    // Serializer decode.
    logic [N_RPT-1:0]  w_head_vec;
    logic [ID_W-1:0]   w_idx;
    logic [N_RPT-1:0]  w_rem;
    logic              w_load;
    logic              w_take;
    logic              w_pop;
    logic              w_capture;
    logic              w_push;
    logic              w_drop;

    assign w_push_data.vec   = report_vec;
    assign w_push_data.stamp = r_cycle_cnt;

    lw_rpt_snap_fifo u_snap_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // Pick the next event from the head snapshot and decide push/pop/drop.
    always_comb begin
        // NOTE: every signal gets a value before any condition so no latch
        // can be inferred.
        w_head_vec = w_head.vec;
        if (r_work_active) begin
            w_head_vec = r_work_vec;
        end
        w_idx     = lowest_set(w_head_vec);
        w_rem     = w_head_vec & ~(N_RPT'(1) << w_idx);
        w_load    = !r_valid || rpt_ready;
        w_take    = w_load && !w_fifo_empty;
        // The head retires in the cycle its last set bit moves out.
        w_pop     = w_take && (w_rem == '0);
        w_capture = run && (report_vec != '0);
        w_push    = w_capture && (!w_fifo_full || w_pop);
        w_drop    = w_capture && !w_push;
    end

    // Cycle counter: advances once per valid symbol, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt <= '0;
        end else if (run) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    // Working copy of the head vector with already-emitted bits cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_work_active <= 1'b0;
            r_work_vec    <= '0;
        end else if (w_take) begin
            r_work_active <= !w_pop;
            r_work_vec    <= w_rem;
        end
    end

    // Output register: reloads when empty or when the current event is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_cycle <= '0;
        end else if (w_load) begin
            r_valid <= w_take;
            if (w_take) begin
                r_id    <= w_idx;
                r_cycle <= w_head.stamp;
            end
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign rpt_valid = r_valid;
    assign rpt_id    = r_id;
    assign rpt_cycle = r_cycle;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_lw_report_collector_c7.sv
// Self-checking bench for lw_report_collector_c7: directed scenarios with
// literal expectations plus randomized traffic against an event-queue model.
module tb_lw_report_collector_c7;
    import lw_rpt_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              run = 1'b0;
    logic [N_RPT-1:0]  report_vec = '0;
    logic              rpt_ready = 1'b0;
    logic              rpt_valid;
    logic [ID_W-1:0]   rpt_id;
    logic [CYC_W-1:0]  rpt_cycle;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lw_report_collector_c7 dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .report_vec (report_vec),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_id     (rpt_id),
        .rpt_cycle  (rpt_cycle),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pending events as a flat queue, plus the number of
    // events still owed by each buffered snapshot (its FIFO occupancy).
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CYC_W-1:0] cyc;
    } ev_t;

    ev_t              ev_q[$];
    int               snap_len[$];
    logic             m_init = 1'b0;
    logic             m_valid;
    logic [ID_W-1:0]  m_id;
    logic [CYC_W-1:0] m_cyc;
    logic             m_ovf;
    int               m_drop;
    logic [CYC_W-1:0] m_cnt;
    ev_t              m_e;
    int               m_n;

    always @(posedge clk) begin
        if (reset) begin
            ev_q.delete();
            snap_len.delete();
            m_init  = 1'b1;
            m_valid = 1'b0;
            m_id    = '0;
            m_cyc   = '0;
            m_ovf   = 1'b0;
            m_drop  = 0;
            m_cnt   = '0;
        end else if (m_init) begin
            if (!m_valid || rpt_ready) begin
                if (ev_q.size() > 0) begin
                    m_e     = ev_q.pop_front();
                    m_id    = m_e.id;
                    m_cyc   = m_e.cyc;
                    m_valid = 1'b1;
                    snap_len[0] = snap_len[0] - 1;
                    if (snap_len[0] == 0) snap_len.delete(0);
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (run && report_vec != '0) begin
                if (snap_len.size() < SNAP_DEPTH) begin
                    m_n = 0;
                    for (int i = 0; i < N_RPT; i++) begin
                        if (report_vec[i]) begin
                            m_e.id  = ID_W'(i);
                            m_e.cyc = m_cnt;
                            ev_q.push_back(m_e);
                            m_n++;
                        end
                    end
                    snap_len.push_back(m_n);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
            if (run) m_cnt = m_cnt + 1;
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_init) begin
            check("model_valid", 64'(rpt_valid), 64'(m_valid));
            check("model_overflow", 64'(overflow), 64'(m_ovf));
            check("model_drop_cnt", 64'(drop_cnt), 64'(m_drop));
            if (m_valid) begin
                check("model_id", 64'(rpt_id), 64'(m_id));
                check("model_cycle", 64'(rpt_cycle), 64'(m_cyc));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. cyc() applies inputs for one cycle; on return the
    // DUT outputs are those of that same cycle.
    // ------------------------------------------------------------------
    task automatic cyc(input logic rs, input logic r, input logic [N_RPT-1:0] v, input logic rdy);
        @(negedge clk);
        reset      = rs;
        run        = r;
        report_vec = v;
        rpt_ready  = rdy;
    endtask

    function automatic logic [N_RPT-1:0] b(input int i);
        logic [N_RPT-1:0] one;
        one = N_RPT'(1);
        return one << i;
    endfunction

    task automatic expect_ev(input string name, input int id, input int cyc_v);
        check({name, "_valid"}, 64'(rpt_valid), 64'd1);
        check({name, "_id"}, 64'(rpt_id), 64'(id));
        check({name, "_cycle"}, 64'(rpt_cycle), 64'(cyc_v));
    endtask

    logic [N_RPT-1:0] rv;
    int               nb;
    int               rdy_pct;

    initial begin
        // ---- 1: stamp of first reporting cycle after 5 quiet run cycles
        cyc(1, 0, '0, 1);
        cyc(0, 1, '0, 1);
        check("rst_valid", 64'(rpt_valid), 64'd0);
        check("rst_id", 64'(rpt_id), 64'd0);
        check("rst_cycle", 64'(rpt_cycle), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        for (int i = 0; i < 4; i++) cyc(0, 1, '0, 1);
        cyc(0, 1, b(0), 1);
        cyc(0, 0, '0, 1);
        check("t1_lat_t1", 64'(rpt_valid), 64'd0);
        cyc(0, 0, '0, 1);
        expect_ev("t1_ev", 0, 5);
        cyc(0, 0, '0, 1);
        check("t1_single", 64'(rpt_valid), 64'd0);

        // ---- 2: three bits in one snapshot, back-to-back
        for (int i = 0; i < 4; i++) cyc(0, 1, '0, 1);
        cyc(0, 1, b(rpt_index(0, 3)) | b(rpt_index(4, 1)) | b(rpt_index(9, 3)), 1);
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 1);
        expect_ev("t2_a", 3, 10);
        cyc(0, 0, '0, 1);
        expect_ev("t2_b", 17, 10);
        cyc(0, 0, '0, 1);
        expect_ev("t2_c", 39, 10);
        cyc(0, 0, '0, 1);
        check("t2_done", 64'(rpt_valid), 64'd0);

        // ---- 3: back-pressure holds the event stable
        cyc(1, 0, '0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, '0, 0);
        cyc(0, 1, b(2) | b(5), 0);
        cyc(0, 0, '0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, '0, 0);
            expect_ev("t3_hold", 2, 4);
        end
        cyc(0, 0, '0, 1);
        expect_ev("t3_x1", 2, 4);
        cyc(0, 0, '0, 1);
        expect_ev("t3_x2", 5, 4);
        cyc(0, 0, '0, 1);
        check("t3_done", 64'(rpt_valid), 64'd0);

        // ---- 4: FIFO fills, 5th and 6th snapshot dropped
        cyc(1, 0, '0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, b(i) | b(i + 20), 0);
        cyc(0, 0, '0, 0);
        check("t4_overflow", 64'(overflow), 64'd1);
        check("t4_drop", 64'(drop_cnt), 64'd2);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, '0, 1);
            expect_ev("t4_drain", (k % 2 == 1) ? (k / 2 + 20) : (k / 2), k / 2);
        end
        cyc(0, 0, '0, 1);
        check("t4_done", 64'(rpt_valid), 64'd0);

        // ---- 5: only run cycles are captured; counter holds otherwise
        cyc(1, 0, '0, 1);
        cyc(0, 1, b(7), 1);
        cyc(0, 0, b(7), 1);
        cyc(0, 0, b(7), 1);
        expect_ev("t5_a", 7, 0);
        cyc(0, 1, b(7), 1);
        check("t5_gap1", 64'(rpt_valid), 64'd0);
        cyc(0, 0, '0, 1);
        check("t5_gap2", 64'(rpt_valid), 64'd0);
        cyc(0, 0, '0, 1);
        expect_ev("t5_b", 7, 1);
        cyc(0, 0, '0, 1);
        check("t5_done", 64'(rpt_valid), 64'd0);

        // ---- 6: reset mid-drain with overflow set
        cyc(1, 0, '0, 0);
        for (int i = 0; i < 6; i++)
            cyc(0, 1, b(i) | b(i + 8) | b(i + 16) | b(i + 24) | b(i + 32), 0);
        cyc(0, 0, '0, 0);
        check("t6_pre_ovf", 64'(overflow), 64'd1);
        cyc(1, 0, '0, 0);
        cyc(0, 1, b(9), 1);
        check("t6_rst_valid", 64'(rpt_valid), 64'd0);
        check("t6_rst_ovf", 64'(overflow), 64'd0);
        check("t6_rst_drop", 64'(drop_cnt), 64'd0);
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 1);
        expect_ev("t6_restamp", 9, 0);

        // ---- randomized traffic checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            rdy_pct = (c < 2000) ? 75 : 30;
            rv = '0;
            if ($urandom_range(0, 1) == 1) begin
                nb = $urandom_range(1, 4);
                for (int k = 0; k < nb; k++) rv = rv | b($urandom_range(0, N_RPT - 1));
            end
            cyc(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                rv,
                ($urandom_range(0, 99) < rdy_pct) ? 1'b1 : 1'b0);
        end
        for (int c = 0; c < 200; c++) cyc(0, 0, '0, 1);
        check("final_idle", 64'(rpt_valid), 64'd0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lw_report_collector_c7.md
Name: lw_report_collector_c7

Overview:
- Sits directly downstream of the cluster-7 lw automata stage.
- Consumes the 40 per-cycle report bits: 10 LTL automata, 4 report outputs each.
- Timestamps each reporting cycle with a symbol-cycle counter, buffers reporting cycles in a small snapshot FIFO, and serializes them.
- Emits one (report id, cycle stamp) event per cycle on a valid/ready interface toward the monitor's report sink.

Parameters:
N_RPT, 40, number of report inputs
ID_W, 6, report id width (ceil log2 N_RPT)
CYC_W, 32, cycle-stamp counter width
SNAP_DEPTH, 4, snapshot FIFO entries (power of 2)
DROP_W, 16, dropped-snapshot counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
run  in  1  symbol-valid qualifier, same cycle as report_vec
report_vec  in  N_RPT  report bits; index = ltl_n*4 + k, ltl_n = 0..9, k = 0..3 for out_4/out_6/out_9/out_11
rpt_valid  out  1  event available
rpt_ready  in  1  sink accepts event
rpt_id  out  ID_W  report index of event
rpt_cycle  out  CYC_W  cycle stamp of event
overflow  out  1  sticky: a snapshot was dropped
drop_cnt  out  DROP_W  dropped snapshots, saturating

Behaviour:
- Reset is synchronous and active-high. On reset, all outputs are 0: rpt_valid, rpt_id, rpt_cycle, overflow, drop_cnt. The cycle counter, snapshot FIFO and serializer state are also cleared.
- Reset asserted mid-drain discards all pending events. rpt_valid is 0 in the cycle after the reset edge.
- Cycle counter:
  - Increments by 1 at each clk edge where run=1; wraps at 2^CYC_W.
  - Holds when run=0.
  - The stamp of a sample is the counter value in its own cycle, before the increment. The first run cycle after reset has stamp 0.
- Capture: when run=1 and report_vec != 0, push {report_vec, stamp} into the snapshot FIFO.
  - Cycles with run=0, or with run=1 and report_vec == 0, push nothing.
- Push acceptance: a push is accepted if the FIFO is not full, or if the head entry retires in the same cycle.
  - Otherwise the snapshot is dropped, overflow is set to 1, and drop_cnt increments, saturating at all-ones.
  - overflow clears only on reset.
- Serializer:
  - The output register loads when empty (rpt_valid=0) or when the current event is taken (rpt_valid & rpt_ready).
  - On load, it takes the lowest set bit of the head working vector: rpt_id = that index, rpt_cycle = head stamp. That bit is cleared in the working copy.
  - The head retires (FIFO pop) in the cycle its last set bit is loaded.
  - Throughput is 1 event/cycle; events within a snapshot go in ascending id order; snapshots go in arrival order.
- Handshake:
  - While rpt_valid=1 and rpt_ready=0, rpt_valid, rpt_id and rpt_cycle hold stable.
  - rpt_valid deasserts only after a transfer when no further event is pending.
  - rpt_ready is ignored while rpt_valid=0.
- Latency: with an idle block and rpt_ready=1, a report sampled in cycle t appears as rpt_valid=1 in cycle t+2. A k-bit snapshot occupies cycles t+2 .. t+1+k.
- The block does not stall run and never back-pressures upstream.

Decomposition:
- Package lw_rpt_pkg holds:
  - constants N_RPT, ID_W, N_LTL=10, RPT_PER_LTL=4;
  - the snapshot struct {vec, stamp};
  - an index helper ltl_n*4+k;
  - a lowest-set-bit priority-encoder function.
- One sub-module, lw_rpt_snap_fifo: synchronous FIFO of snapshot structs with full/empty flags and same-cycle push/pop support.
- The counter, serializer and output register live in the top.

Test Plan:
1. Reset, run=1 with report_vec=0 for 5 cycles, then bit 0 set in the 6th (stamp 5) -> exactly one event, id=0, cycle=5, rpt_valid first high 2 cycles after the sample.
2. Bits 3, 17 and 39 set at stamp 10, rpt_ready=1 -> three consecutive events with ids 3, 17, 39, all cycle=10, then rpt_valid=0.
3. Bits 2 and 5 at stamp 4, rpt_ready=0 for 10 cycles -> id=2/cycle=4 held stable throughout; after rpt_ready=1, id=2 then id=5; no loss.
4. SNAP_DEPTH=4, rpt_ready=0, six two-bit snapshots on consecutive run cycles:
   - the first snapshot stays at the FIFO head (one bit pending, one in the output register); the next three fill the FIFO;
   - the 5th and 6th are dropped: overflow=1, drop_cnt=2;
   - after rpt_ready=1, 8 events drain in order.
5. run toggled 1,0,0,1 with report_vec nonzero on every cycle -> only the run=1 cycles are captured, with stamps 0 and 1; the counter holds during run=0.
6. Reset asserted while 20 events are pending and overflow=1 -> rpt_valid=0, overflow=0, drop_cnt=0 next cycle; the next run report is stamped 0.
